// File: rtl/core_seq_ctrl_pkg.sv
// Shared definitions for the core_seq_ctrl instruction sequencer.
//   SEQ_STATE_WIDTH : width of the sequencer state / debug state port
//   SEQ_TIMEOUT_CYC : default handshake watchdog limit in cycles
//   seq_state_e     : sequencer state encoding, also exported on state_o
package core_seq_ctrl_pkg;

    localparam int unsigned SEQ_STATE_WIDTH = 3;
    localparam int unsigned SEQ_TIMEOUT_CYC = 255;

    typedef enum logic [SEQ_STATE_WIDTH-1:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_FETCH  = 3'd1,
        SEQ_DECODE = 3'd2,
        SEQ_EXEC   = 3'd3,
        SEQ_MEM    = 3'd4,
        SEQ_WB     = 3'd5,
        SEQ_HALT   = 3'd6,
        SEQ_TRAP   = 3'd7
    } seq_state_e;

endpackage

// File: rtl/seq_wait_cnt.sv
// Handshake wait counter shared by FETCH, EXEC (multi-cycle op) and MEM.
// Ports:
//   clk, rst : core clock, synchronous active-high reset
//   clr      : clear the count (takes priority over en)
//   en       : count up by one this cycle
//   timeout  : count has reached LIMIT
// CNT_W must satisfy 2^CNT_W > LIMIT; the owner leaves the wait state at LIMIT,
// so the count never wraps.
module seq_wait_cnt
    import core_seq_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned LIMIT = SEQ_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = (cnt_q == CNT_W'(LIMIT));

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle instruction sequencer: steps each instruction through
// FETCH -> DECODE -> EXEC -> MEM -> WB and gates the IFU, LSU, multi-cycle ALU
// and register-file enables. Handles ebreak halt, unknown-instruction trap and
// a handshake watchdog.
// Ports:
//   clk, rst            : core clock, synchronous active-high reset
//   ifu_req / ifu_ack   : instruction fetch request (level) / fetch data valid
//   inst_latch_en       : pulse, capture instruction register
//   dec_*               : decoder flags, stable from DECODE through WB
//   mdu_start/mdu_done  : multi-cycle ALU start pulse / result valid
//   lsu_req/lsu_we/ack  : data memory request (level), write qualifier, complete
//   rf_wen, pc_wen      : register-file write / PC update pulses (WB)
//   retire              : instruction retired pulse
//   halted, trap        : sticky status levels
//   state_o             : current state for debug/difftest
// Optional build macro CORE_SEQ_PERF_EN adds perf_cycle, perf_instret (64-bit,
// wrapping) and perf_stall (32-bit, saturating wait-cycle count).
module core_seq_ctrl
    import core_seq_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = SEQ_TIMEOUT_CYC,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       ifu_req,
    input  logic                       ifu_ack,
    output logic                       inst_latch_en,
    input  logic                       dec_reg_wen,
    input  logic                       dec_is_load,
    input  logic                       dec_is_store,
    input  logic                       dec_is_mdu,
    input  logic                       dec_ebreak,
    input  logic                       dec_unknown,
    output logic                       mdu_start,
    input  logic                       mdu_done,
    output logic                       lsu_req,
    output logic                       lsu_we,
    input  logic                       lsu_ack,
    output logic                       rf_wen,
    output logic                       pc_wen,
    output logic                       retire,
    output logic                       halted,
    output logic                       trap,
    output logic [SEQ_STATE_WIDTH-1:0] state_o
`ifdef CORE_SEQ_PERF_EN
    ,
    output logic [63:0]                perf_cycle,
    output logic [63:0]                perf_instret,
    output logic [31:0]                perf_stall
`endif
);

    seq_state_e state_q, state_d;
    logic       wait_en;
    logic       wait_clr;
    logic       wait_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ifu_req       = 1'b0;
        inst_latch_en = 1'b0;
        mdu_start     = 1'b0;
        lsu_req       = 1'b0;
        lsu_we        = 1'b0;
        rf_wen        = 1'b0;
        pc_wen        = 1'b0;
        retire        = 1'b0;
        halted        = 1'b0;
        trap          = 1'b0;
        wait_en       = 1'b0;
        case (state_q)
            SEQ_IDLE: state_d = SEQ_FETCH;
            SEQ_FETCH: begin
                ifu_req = 1'b1;
                wait_en = 1'b1;
                // An ack in the timeout cycle still wins.
                if (ifu_ack) begin
                    inst_latch_en = 1'b1;
                    state_d       = SEQ_DECODE;
                end else if (wait_timeout) begin
                    state_d = SEQ_TRAP;
                end
            end
            SEQ_DECODE: begin
                if (dec_unknown) begin
                    state_d = SEQ_TRAP;
                end else if (dec_ebreak) begin
                    state_d = SEQ_HALT;
                end else begin
                    mdu_start = dec_is_mdu;
                    state_d   = SEQ_EXEC;
                end
            end
            SEQ_EXEC: begin
                if (!dec_is_mdu || mdu_done) begin
                    state_d = (dec_is_load || dec_is_store) ? SEQ_MEM : SEQ_WB;
                end else begin
                    wait_en = 1'b1;
                    if (wait_timeout) begin
                        state_d = SEQ_TRAP;
                    end
                end
            end
            SEQ_MEM: begin
                lsu_req = 1'b1;
                lsu_we  = dec_is_store;
                wait_en = 1'b1;
                if (lsu_ack) begin
                    state_d = SEQ_WB;
                end else if (wait_timeout) begin
                    state_d = SEQ_TRAP;
                end
            end
            SEQ_WB: begin
                // The decoder raises reg_wen for stores too; suppress it here.
                rf_wen  = dec_reg_wen && !dec_is_store;
                pc_wen  = 1'b1;
                retire  = 1'b1;
                state_d = SEQ_FETCH;
            end
            SEQ_HALT: halted = 1'b1;
            SEQ_TRAP: trap = 1'b1;
            default:  state_d = SEQ_TRAP;
        endcase
    end

    // Every state change restarts the watchdog.
    assign wait_clr = (state_d != state_q);

    seq_wait_cnt #(
        .CNT_W (CNT_W),
        .LIMIT (TIMEOUT_CYC)
    ) u_wait_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (wait_clr),
        .en      (wait_en),
        .timeout (wait_timeout)
    );

    assign state_o = state_q;

`ifdef CORE_SEQ_PERF_EN
    logic        stall;
    logic        active;
    logic [63:0] perf_cycle_q;
    logic [63:0] perf_instret_q;
    logic [31:0] perf_stall_q;

    assign active = (state_q != SEQ_IDLE) && (state_q != SEQ_HALT) && (state_q != SEQ_TRAP);
    assign stall  = ((state_q == SEQ_FETCH) && !ifu_ack) ||
                    ((state_q == SEQ_EXEC) && dec_is_mdu && !mdu_done) ||
                    ((state_q == SEQ_MEM) && !lsu_ack);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycle_q   <= '0;
            perf_instret_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (active) begin
                perf_cycle_q <= perf_cycle_q + 64'd1;
            end
            if (retire) begin
                perf_instret_q <= perf_instret_q + 64'd1;
            end
            if (stall && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_cycle   = perf_cycle_q;
    assign perf_instret = perf_instret_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule
